// File: rtl/adder_ring_counter_pkg.sv
// Shared types and default widths for the adder ring-oscillator measurement stage.
package adder_ring_pkg;

    localparam int unsigned DEFAULT_COUNT_W = 32;
    localparam int unsigned DEFAULT_WIN_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_ring_counter_if.sv
// LA control/status bundle: start and window length in, measurement result out.
interface adder_ring_counter_if
    import adder_ring_pkg::*;
#(
    parameter int unsigned COUNT_W = DEFAULT_COUNT_W,
    parameter int unsigned WIN_W   = DEFAULT_WIN_W
);

    logic               start;
    logic [WIN_W-1:0]   window_cycles;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] count;
    logic               overflow;

    modport master (
        output start, window_cycles,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, window_cycles,
        output busy, done, count, overflow
    );

endinterface

// File: rtl/adder_ring_counter_ring_sync_edge.sv
// Two-flop synchroniser for an asynchronous ring tap with rising-edge detection.
module ring_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic ring_in,
    output logic ring_edge
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronise the ring and keep one cycle of history for the edge compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ring_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ring_edge = s2 & ~s3;

endmodule

// File: rtl/adder_ring_counter.sv
// Counts rising edges of the adder ring output over a programmable clock window.
module adder_ring_counter
    import adder_ring_pkg::*;
#(
    parameter int unsigned COUNT_W = DEFAULT_COUNT_W,
    parameter int unsigned WIN_W   = DEFAULT_WIN_W
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  ring_in,
    adder_ring_counter_if.slave   bus
);

    localparam logic [COUNT_W-1:0] ACC_MAX = '1;
    localparam logic [COUNT_W-1:0] ACC_ONE = COUNT_W'(1);
    localparam logic [WIN_W-1:0]   WIN_ONE = WIN_W'(1);

    state_t             state;
    logic [COUNT_W-1:0] acc;
    logic [COUNT_W-1:0] acc_next;
    logic               ovf_next;
    logic [WIN_W-1:0]   timer;
    logic               ring_edge;

    ring_sync_edge u_sync (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .ring_in   (ring_in),
        .ring_edge (ring_edge)
    );

    // Saturating accumulate; the result also feeds count on the final cycle.
    always_comb begin
        acc_next = acc;
        ovf_next = bus.overflow;
        if (ring_edge) begin
            if (acc == ACC_MAX) begin
                ovf_next = 1'b1;
            end else begin
                acc_next = acc + ACC_ONE;
            end
        end
    end

    // Measurement FSM with registered status outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.count    <= '0;
            bus.overflow <= 1'b0;
            acc          <= '0;
            timer        <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        acc          <= '0;
                        bus.overflow <= 1'b0;
                        timer        <= bus.window_cycles;
                        if (bus.window_cycles == '0) begin
                            state     <= DONE;
                            bus.busy  <= 1'b0;
                            bus.done  <= 1'b1;
                            bus.count <= '0;
                        end else begin
                            state    <= COUNT;
                            bus.busy <= 1'b1;
                            bus.done <= 1'b0;
                        end
                    end
                end
                COUNT: begin
                    acc          <= acc_next;
                    bus.overflow <= ovf_next;
                    timer        <= timer - WIN_ONE;
                    if (timer == WIN_ONE) begin
                        state     <= DONE;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.count <= acc_next;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/adder_ring_counter.md
Name: adder_ring_counter

Overview:
- Downstream measurement stage for the instrumented adder. It consumes the adder's free-running ring/chain output (`chain_out`) and counts its rising edges over a programmable window of `wb_clk_i` cycles.
- The resulting count gives the ring oscillation frequency, and therefore the adder path delay.
- Sits between the instrumented adder and the LA readback registers. Control comes from LA `start` / `window_cycles`; `count`, `done` and `overflow` are read back over LA.

Parameters:
- COUNT_W, 32, width of the edge counter and `count` result.
- WIN_W, 32, width of the window length and the internal timer.

Ports:
- wb_clk_i  input  1  system clock; all state on its rising edge.
- wb_rst_i  input  1  asynchronous, active-high reset.
- ring_in  input  1  `chain_out` from the instrumented adder; asynchronous to `wb_clk_i`.
- start  input  1  level sampled each cycle; starts a measurement when the FSM is IDLE or DONE.
- window_cycles  input  WIN_W  measurement window length in clocks; sampled on an accepted start.
- busy  output  1  high while the FSM is COUNT.
- done  output  1  high in DONE; sticky until the next accepted start.
- count  output  COUNT_W  result register; edges seen in the last completed window.
- overflow  output  1  the last window's counter saturated.

Behaviour:
- Clock and reset: one clock, `wb_clk_i`. Reset `wb_rst_i` is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, count=0, overflow=0, accumulator=0, timer=0, sync flops=0.
- Synchroniser:
  - `ring_in` passes through 2 flops (s1, s2), plus a history flop s3.
  - edge = s2 & ~s3.
  - The pipeline runs in every state; edges are accumulated only in COUNT.
  - Edge latency from `ring_in` rising to edge=1 is 2 cycles.
  - `ring_in` period of 4 clocks or less is out of spec; no error detection.
- States: IDLE, COUNT, DONE (2-bit encoding).
- Accepted start (start=1 in IDLE or DONE):
  - Next cycle: accumulator←0, overflow←0, done←0, timer←window_cycles.
  - If window_cycles==0: state→DONE, count←0.
  - Otherwise: state→COUNT.
- start while in COUNT is ignored. start held high re-triggers on the first cycle in DONE.
- COUNT, each cycle:
  - If edge: when accumulator == 2^COUNT_W−1, accumulator holds and overflow←1; otherwise accumulator←accumulator+1.
  - timer←timer−1.
  - When timer==1 this cycle: state→DONE and count←final accumulator, including any edge on this same cycle.
  - COUNT therefore lasts exactly window_cycles cycles.
- Timing: start sampled at cycle t → busy=1 for cycles t+1..t+N → done=1 from t+N+1.
- `count` changes only at window end, at a zero-window start, or on reset. It is stable and readable at all other times.
- DONE: done=1, busy=0. Remains in DONE until an accepted start.
- Reset mid-COUNT: immediate return to reset values. The partial count is discarded.

Decomposition:
- Package adder_ring_pkg: state enum (IDLE, COUNT, DONE), default widths COUNT_W/WIN_W.
- Sub-module ring_sync_edge: 2-flop synchroniser plus rising-edge detect, output `edge`. Reused for other async ring taps.

Test Plan:
- Reset: assert wb_rst_i asynchronously mid-cycle → all outputs 0 immediately; state IDLE after release.
- Basic count:
  - Stimulus: bench drives ring_in synchronously with period 8 clocks (4 high/4 low), first rise 3 cycles after start; start=1 for one cycle; window_cycles=80.
  - Required response: busy high for 80 cycles, done at t+81, count=10, overflow=0.
- Zero window: window_cycles=0 with ring toggling → done=1 on the next cycle, count=0, busy never high.
- Saturation:
  - Stimulus: COUNT_W=4, ring period 6, window_cycles=120.
  - Required response: count=15, overflow=1; a following window of 30 cycles gives count=5, overflow=0.
- Start while busy: pulse start in mid-window with window_cycles changed to 5 → ignored; original 80-cycle window completes with count=10.
- Reset mid-COUNT: after 40 cycles of the basic-count window, pulse wb_rst_i → count=0, done=0; a new start gives count=10 again.
